mem_arbiter: RTL and testbench

- Shares one mem_system instance (2-way set-associative cache over four_bank_mem) between two requesters: instruction fetch (read-only) and data memory (read/write).
- Sits between the fetch/memory pipeline stages and the shared cache.
- Grants one transaction at a time and holds the downstream request stable until Done.
- Routes Done/DataOut/CacheHit/err back to the owning requester.
- Default policy is data-priority with a starvation bound for fetch.

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of a single shared mem_system.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin ties instead of data priority with a fetch starvation bound.
module mem_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [AW-1:0] i_rdata,
  output logic          i_done,
  output logic          i_stall,
  output logic          i_err,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] d_wdata,
  output logic [AW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_hit,
  output logic          d_stall,
  output logic          d_err,
  output logic [AW-1:0] m_addr,
  output logic [AW-1:0] m_wdata,
  output logic          m_rd,
  output logic          m_wr,
  input  logic [AW-1:0] m_rdata,
  input  logic          m_done,
  input  logic          m_hit,
  input  logic          m_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    D_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;

  logic          d_req_s;
  logic          d_illegal_s;
  logic          grant_d_s;
  logic          i_fin_s;
  logic          d_fin_s;
  logic          err_cyc_s;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when fetch owned the most recent grant; data wins the next tie in that case
  logic          last_i_q, last_i_d;
`else
  localparam int            SW    = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_STARVE);
  logic [SW-1:0] starve_q, starve_d;
`endif

  assign d_req_s     = d_rd | d_wr;
  assign d_illegal_s = d_rd & d_wr;

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d_s = d_req_s & ~d_illegal_s & (~i_req | last_i_q);
`else
  assign grant_d_s = d_req_s & ~d_illegal_s & (~i_req | (starve_q < MAX_S));
`endif

  // Next-state, request latch and fairness bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_i_d = last_i_q;
`else
    starve_d = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_illegal_s) begin
          state_d = D_ERR;
        end else if (grant_d_s) begin
          state_d = D_BUSY;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          rd_d    = d_rd;
          wr_d    = d_wr;
        end else if (i_req) begin
          state_d = I_BUSY;
          addr_d  = i_addr;
          wdata_d = {AW{1'b0}};
          rd_d    = 1'b1;
          wr_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (grant_d_s) begin
          last_i_d = 1'b0;
        end else if (i_req && !d_illegal_s) begin
          last_i_d = 1'b1;
        end else begin
          last_i_d = last_i_q;
        end
`else
        // grant_d_s already requires starve_q < MAX_S while i_req is high, so this saturates
        if (!i_req) begin
          starve_d = {SW{1'b0}};
        end else if (grant_d_s) begin
          starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
        end else if (!d_illegal_s) begin
          starve_d = {SW{1'b0}};
        end else begin
          starve_d = starve_q;
        end
`endif
      end
      I_BUSY, D_BUSY: begin
        if (m_done) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      D_ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and latched downstream request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= {AW{1'b0}};
      wdata_q  <= {AW{1'b0}};
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_i_q <= 1'b0;
`else
      starve_q <= {SW{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_i_q <= last_i_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_rd    = rd_q;
  assign m_wr    = wr_q;

  // Completion is routed to whoever owns the current transaction, in the same cycle as m_done
  assign i_fin_s   = (state_q == I_BUSY) & m_done;
  assign d_fin_s   = (state_q == D_BUSY) & m_done;
  assign err_cyc_s = (state_q == D_ERR);

  assign i_done  = i_fin_s;
  assign i_rdata = i_fin_s ? m_rdata : {AW{1'b0}};
  assign i_err   = i_fin_s & m_err;
  assign i_stall = i_req & ~i_fin_s;

  assign d_done  = d_fin_s | err_cyc_s;
  assign d_rdata = d_fin_s ? m_rdata : {AW{1'b0}};
  assign d_hit   = d_fin_s & m_hit;
  assign d_err   = (d_fin_s & m_err) | err_cyc_s;
  assign d_stall = d_req_s & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expectations, a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [AW-1:0] i_rdata;
  logic          i_done, i_stall, i_err;
  logic          d_rd, d_wr;
  logic [AW-1:0] d_addr, d_wdata, d_rdata;
  logic          d_done, d_hit, d_stall, d_err;
  logic [AW-1:0] m_addr, m_wdata, m_rdata;
  logic          m_rd, m_wr, m_done, m_hit, m_err;

  mem_arbiter #(.MAX_STARVE(4), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .i_stall(i_stall), .i_err(i_err),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_hit(d_hit), .d_stall(d_stall), .d_err(d_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_done(m_done), .m_hit(m_hit), .m_err(m_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        hit;
    logic        err;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        i_exp_q[$];
  exp_t        d_exp_q[$];
  logic [7:0]  grant_log[$];
  logic [15:0] mem_arr [0:1023];
  logic [15:0] ref_mem [0:1023];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'd37) ^ 16'h5A5A;
  endfunction
  function automatic logic hit_of(input logic [15:0] a);
    return ~(a[1] ^ a[4]);
  endfunction
  function automatic logic err_of(input logic [15:0] a);
    return (a[5:0] == 6'h3F);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder (stands in for mem_system) ----------------
  bit          hold_mem = 1'b0;
  int          fixed_lat = -1;
  bit          pend = 1'b0;
  int          lat;
  logic [15:0] p_addr, p_wdata;
  logic        p_wr;

  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem_arr[k] = init_val(16'(k));
      ref_mem[k] = init_val(16'(k));
    end
    m_done = 1'b0; m_rdata = 16'h0000; m_hit = 1'b0; m_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_done = 1'b0; m_rdata = 16'h0000; m_hit = 1'b0; m_err = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (!pend && (m_rd || m_wr)) begin
          pend    = 1'b1;
          p_addr  = m_addr;
          p_wdata = m_wdata;
          p_wr    = m_wr;
          lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3, 0));
        end
        if (pend && !hold_mem) begin
          if (lat == 0) begin
            m_done  = 1'b1;
            m_rdata = mem_arr[p_addr[9:0]];
            m_hit   = hit_of(p_addr);
            m_err   = err_of(p_addr);
            if (p_wr && !m_err) mem_arr[p_addr[9:0]] = p_wdata;
            pend = 1'b0;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t ei, ed;
  bit   prev_done = 1'b0;
  bit   strobe_seen = 1'b0;
  int   run_len = 0;
  int   last_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (prev_done) chk("idle_gap", {30'd0, m_rd, m_wr}, 32'd0);
      if (m_rd || m_wr) begin
        strobe_seen = 1'b1;
        run_len++;
      end else if (run_len != 0) begin
        last_len = run_len;
        run_len  = 0;
      end
      if (i_done) begin
        grant_log.push_back(8'h49);
        if (i_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL i_done_unexpected: got done=1 expected no fetch completion at %0t", $time);
        end else begin
          ei = i_exp_q.pop_front();
          chk("i_rdata", 32'(i_rdata), 32'(ei.rdata));
          chk("i_err", 32'(i_err), 32'(ei.err));
        end
      end else begin
        chk("i_rdata_idle", 32'(i_rdata), 32'd0);
      end
      if (d_done) begin
        grant_log.push_back(8'h44);
        if (d_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_done_unexpected: got done=1 expected no data completion at %0t", $time);
        end else begin
          ed = d_exp_q.pop_front();
          chk("d_rdata", 32'(d_rdata), 32'(ed.rdata));
          chk("d_hit", 32'(d_hit), 32'(ed.hit));
          chk("d_err", 32'(d_err), 32'(ed.err));
        end
      end else begin
        chk("d_rdata_idle", 32'(d_rdata), 32'd0);
      end
      prev_done = i_done | d_done;
    end else begin
      prev_done = 1'b0;
      run_len   = 0;
    end
  end

  // ---------------- requesters ----------------
  task automatic wait_done(input bit is_d);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = is_d ? d_done : i_done;
      if (!seen) begin
        if (is_d) chk("d_stall", 32'(d_stall), 32'd1);
        else      chk("i_stall", 32'(i_stall), 32'd1);
      end
      n++;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles (data=%0d)", is_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic fetch_txn(input logic [15:0] a);
    exp_t e;
    e.rdata = ref_mem[a[9:0]];
    e.hit   = 1'b0;
    e.err   = err_of(a);
    i_exp_q.push_back(e);
    i_req  = 1'b1;
    i_addr = a;
    wait_done(1'b0);
  endtask

  task automatic data_txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    exp_t e;
    bit   bad;
    bad     = rd & wr;
    e.rdata = bad ? 16'h0000 : ref_mem[a[9:0]];
    e.hit   = bad ? 1'b0 : hit_of(a);
    e.err   = bad ? 1'b1 : err_of(a);
    d_exp_q.push_back(e);
    d_rd = rd; d_wr = wr; d_addr = a; d_wdata = wd;
    wait_done(1'b1);
    if (wr && !rd && !err_of(a)) ref_mem[a[9:0]] = wd;
  endtask

  function automatic logic [15:0] rnd_daddr();
    return 16'h0100 + 16'($urandom_range(255, 0));
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  string exp_order = "IDIDIDIDID";
  int    n_i = 5, n_d = 5;
`else
  string exp_order = "DDDDIDDDDI";
  int    n_i = 2, n_d = 8;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = 16'h0000;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {30'd0, m_rd, m_wr}, 32'd0);
    chk("rst_dones", {30'd0, i_done, d_done}, 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_errs", {30'd0, i_err, d_err}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // fetch only, fixed 3-cycle access
    mem_arr[16'h0040] = 16'h1234;
    ref_mem[16'h0040] = 16'h1234;
    fixed_lat = 2;
    fetch_txn(16'h0040);
    i_req = 1'b0;
    fixed_lat = -1;
    @(negedge clk); @(posedge clk); #1;
    chk("m_rd_len", 32'(last_len), 32'd3);
    chk("i_stall_idle", 32'(i_stall), 32'd0);

    // data write then read-back
    data_txn(1'b0, 1'b1, 16'h0100, 16'hBEEF);
    chk("m_wdata", 32'(p_wdata), 32'h0000BEEF);
    chk("m_wr_on_write", 32'(p_wr), 32'd1);
    data_txn(1'b1, 1'b0, 16'h0100, 16'h0000);
    d_rd = 1'b0; d_wr = 1'b0;
    @(posedge clk); #1;

    // illegal rd+wr
    strobe_seen = 1'b0;
    data_txn(1'b1, 1'b1, 16'h0104, 16'h1111);
    d_rd = 1'b0; d_wr = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("illegal_no_strobe", 32'(strobe_seen), 32'd0);

    // contention with both requests held continuously
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < n_i; k++) fetch_txn(16'($urandom_range(255, 0)));
        i_req = 1'b0;
      end
      begin
        for (int k = 0; k < n_d; k++) data_txn(1'b1, 1'b0, rnd_daddr(), 16'h0000);
        d_rd = 1'b0; d_wr = 1'b0;
      end
    join
    chk("grant_count", 32'(grant_log.size()), 32'd10);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      chk($sformatf("grant_%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));

    // reset in the middle of a data write
    hold_mem = 1'b1;
    d_rd = 1'b0; d_wr = 1'b1; d_addr = 16'h0120; d_wdata = 16'hCAFE;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!m_wr && n < 20);
      chk("m_wr_before_rst", 32'(m_wr), 32'd1);
    end
    rst = 1'b0;
    #1;
    chk("m_wr_async_drop", {30'd0, m_rd, m_wr}, 32'd0);
    chk("rst_no_d_done", 32'(d_done), 32'd0);
    @(negedge clk);
    rst = 1'b1; d_wr = 1'b0; hold_mem = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("abandoned_write", 32'(mem_arr[16'h0120]), 32'(init_val(16'h0120)));
    fetch_txn(16'h0080);
    i_req = 1'b0;
    @(posedge clk); #1;

    // randomized traffic on both ports
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          fetch_txn(16'($urandom_range(255, 0)));
          if ($urandom_range(1, 0) == 1) begin
            i_req = 1'b0;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
          end
        end
        i_req = 1'b0;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          int sel;
          sel = int'($urandom_range(9, 0));
          if (sel == 0)     data_txn(1'b1, 1'b1, rnd_daddr(), 16'($urandom));
          else if (sel < 5) data_txn(1'b0, 1'b1, rnd_daddr(), 16'($urandom));
          else              data_txn(1'b1, 1'b0, rnd_daddr(), 16'h0000);
          if ($urandom_range(1, 0) == 1) begin
            d_rd = 1'b0; d_wr = 1'b0;
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
          end
        end
        d_rd = 1'b0; d_wr = 1'b0;
      end
    join

    repeat (5) @(posedge clk);
    chk("i_queue_drained", 32'(i_exp_q.size()), 32'd0);
    chk("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
